// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the round-robin AHB arbiter.
package ahb_arb_pkg;

    localparam int MAX_MASTERS = 16;
    localparam int IDX_W       = $clog2(MAX_MASTERS);

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_t;

    // OR of set-bit indices; exact for a one-hot input, no priority chain.
    function automatic logic [IDX_W-1:0] onehot2idx(input logic [MAX_MASTERS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int MW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [MW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    // Two passes: requesters above 'last' first, then the wrap-around from index 0.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i] && (i > int'(last))) begin
                gnt[i] = 1'b1;
                valid  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!valid && req[i]) begin
                gnt[i] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_rr.sv
// Round-robin AHB arbiter with lock hold and default-master fallback.
// Split masking is built only when AHB_ARB_SPLIT_EN is defined.
module ahb_arbiter_rr
    import ahb_arb_pkg::*;
#(
    parameter  int N_MASTERS      = 16,
    parameter  int DEFAULT_MASTER = 0,
    localparam int MW             = $clog2(N_MASTERS)
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [N_MASTERS-1:0] HBUSREQx,
    input  logic [N_MASTERS-1:0] HLOCKx,
    input  logic [N_MASTERS-1:0] HSPLIT,
    input  logic [1:0]           HRESP,
    input  logic                 HREADY,
    output logic [N_MASTERS-1:0] HGRANTx,
    output logic [MW-1:0]        HMASTER,
    output logic                 HMASTLOCK
);

    localparam logic [N_MASTERS-1:0] DEF_GNT = N_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0]        DEF_IDX = MW'(DEFAULT_MASTER);

    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [MW-1:0]          last_q, last_d;
    logic [MW-1:0]          hmaster_q, hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [N_MASTERS-1:0]   splitmask;
    logic [N_MASTERS-1:0]   eligible;
    logic [N_MASTERS-1:0]   pick_gnt;
    logic                   pick_valid;
    logic [MAX_MASTERS-1:0] grant_wide, pick_wide;
    logic [IDX_W-1:0]       grant_idx_full, pick_idx_full;
    logic [MW-1:0]          grant_idx, pick_idx;
    logic                   lock_hold;
    logic                   unused_idx_hi;

    always_comb begin
        grant_wide                   = '0;
        grant_wide[N_MASTERS-1:0]    = grant_q;
        pick_wide                    = '0;
        pick_wide[N_MASTERS-1:0]     = pick_gnt;
    end

    assign grant_idx_full = onehot2idx(grant_wide);
    assign pick_idx_full  = onehot2idx(pick_wide);
    assign grant_idx      = grant_idx_full[MW-1:0];
    assign pick_idx       = pick_idx_full[MW-1:0];
    assign unused_idx_hi  = ^{grant_idx_full, pick_idx_full};

`ifdef AHB_ARB_SPLIT_EN
    logic [N_MASTERS-1:0] splitmask_q, splitmask_d, split_set;

    // Clear is applied after set so a same-cycle collision leaves the bit clear.
    always_comb begin
        split_set = '0;
        if (hresp_t'(HRESP) == SPLIT && !HREADY) split_set[hmaster_q] = 1'b1;
        splitmask_d = (splitmask_q | split_set) & ~HSPLIT;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) splitmask_q <= '0;
        else        splitmask_q <= splitmask_d;
    end

    assign splitmask = splitmask_q;
`else
    logic unused_split;
    assign splitmask    = '0;
    assign unused_split = ^{HSPLIT, HRESP};
`endif

    assign eligible  = HBUSREQx & ~splitmask;
    // A masked owner is not eligible, so its lock cannot keep the grant.
    assign lock_hold = HLOCKx[grant_idx] & eligible[grant_idx];

    rr_pick #(.N(N_MASTERS), .MW(MW)) u_pick (
        .req   (eligible),
        .last  (last_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        grant_d     = grant_q;
        last_d      = last_q;
        hmaster_d   = hmaster_q;
        hmastlock_d = hmastlock_q;
        if (HREADY) begin
            hmaster_d   = grant_idx;
            hmastlock_d = HLOCKx[grant_idx];
            if (!lock_hold) begin
                if (pick_valid) begin
                    grant_d = pick_gnt;
                    last_d  = pick_idx;
                end else begin
                    grant_d = DEF_GNT;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            grant_q     <= DEF_GNT;
            last_q      <= DEF_IDX;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            last_q      <= last_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
        end
    end

    assign HGRANTx   = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Self-checking bench for ahb_arbiter_rr (4 masters, default master 2).
module tb_ahb_arbiter_rr;

    localparam int N   = 4;
    localparam int DEF = 2;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic [N-1:0] HBUSREQx, HLOCKx, HSPLIT;
    logic [1:0]   HRESP;
    logic         HREADY;
    logic [N-1:0] HGRANTx;
    logic [1:0]   HMASTER;
    logic         HMASTLOCK;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    ahb_arbiter_rr #(.N_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQx  (HBUSREQx),
        .HLOCKx    (HLOCKx),
        .HSPLIT    (HSPLIT),
        .HRESP     (HRESP),
        .HREADY    (HREADY),
        .HGRANTx   (HGRANTx),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [3:0] g, input logic [1:0] hm, input logic hl);
        chk({name, "_grant"}, 32'(HGRANTx), 32'(g));
        chk({name, "_hmaster"}, 32'(HMASTER), 32'(hm));
        chk({name, "_hmastlock"}, 32'(HMASTLOCK), 32'(hl));
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Reference model: owner index, last winner, address-phase owner and split mask.
    logic [1:0] m_g, m_last, m_hm;
    logic       m_hl;
    logic [3:0] m_mask;
    logic [1:0] t_g, t_last;
    logic [3:0] t_mask, t_elig;
    int         t_c;
    bit         t_found;

    always @(posedge HCLK) begin
        if (HRESET) begin
            m_g    <= 2'(DEF);
            m_last <= 2'(DEF);
            m_hm   <= 2'(DEF);
            m_hl   <= 1'b0;
            m_mask <= '0;
        end else begin
            t_g    = m_g;
            t_last = m_last;
            t_mask = m_mask;
`ifdef AHB_ARB_SPLIT_EN
            t_elig = HBUSREQx & ~m_mask;
`else
            t_elig = HBUSREQx;
`endif
            if (HREADY) begin
                m_hm <= m_g;
                m_hl <= HLOCKx[m_g];
                if (!(HLOCKx[m_g] && t_elig[m_g])) begin
                    t_found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        t_c = (int'(m_last) + k) % N;
                        if (!t_found && t_elig[t_c[1:0]]) begin
                            t_g     = t_c[1:0];
                            t_last  = t_c[1:0];
                            t_found = 1'b1;
                        end
                    end
                    if (!t_found) t_g = 2'(DEF);
                end
            end
`ifdef AHB_ARB_SPLIT_EN
            if (HRESP == 2'b11 && !HREADY) t_mask[m_hm] = 1'b1;
            t_mask = t_mask & ~HSPLIT;
`endif
            m_g    <= t_g;
            m_last <= t_last;
            m_mask <= t_mask;
        end
    end

    always @(negedge HCLK) begin
        if (chk_en) begin
            chk("onehot", 32'($countones(HGRANTx)), 32'd1);
            chk("model_grant", 32'(HGRANTx), 32'(4'b0001 << m_g));
            chk("model_hmaster", 32'(HMASTER), 32'(m_hm));
            chk("model_hmastlock", 32'(HMASTLOCK), 32'(m_hl));
        end
    end

    logic [3:0] rot_g  [6] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] rot_hm [6] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [3:0] stall_req  [5] = '{4'b0001, 4'b0110, 4'b1111, 4'b0100, 4'b0010};
    logic [3:0] stall_lock [5] = '{4'b1111, 4'b0001, 4'b0110, 4'b0100, 4'b1011};

    initial begin
        HRESET   = 1'b1;
        HBUSREQx = '0;
        HLOCKx   = '0;
        HSPLIT   = '0;
        HRESP    = 2'b00;
        HREADY   = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        HRESET = 1'b0;

        // idle: default master stays granted
        for (int i = 0; i < 4; i++) begin
            step();
            lit("idle", 4'b0100, 2'd2, 1'b0);
        end

        // all request: rotation 3,0,1,2,...
        HBUSREQx = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            lit("rotate", rot_g[i], rot_hm[i], 1'b0);
        end

        // reset in the middle of traffic
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        lit("reset_mid", 4'b0100, 2'd2, 1'b0);

        // locked master 1 holds the bus against 0 and 3
        HBUSREQx = 4'b0010;
        HLOCKx   = 4'b0010;
        step();
        lit("lock_first", 4'b0010, 2'd2, 1'b0);
        HBUSREQx = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            step();
            lit("lock_hold", 4'b0010, 2'd1, 1'b1);
        end
        HLOCKx = 4'b0000;
        step();
        lit("lock_release", 4'b1000, 2'd1, 1'b0);

        // HREADY low: everything holds while requests move
        HREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            HBUSREQx = stall_req[i];
            HLOCKx   = stall_lock[i];
            step();
            lit("stall", 4'b1000, 2'd1, 1'b0);
        end
        HREADY   = 1'b1;
        HBUSREQx = 4'b0001;
        HLOCKx   = 4'b1000;
        step();
        lit("stall_release", 4'b0001, 2'd3, 1'b1);

        // split scenario with master 1 owning the address phase
        HRESET = 1'b1;
        HLOCKx = 4'b0000;
        step();
        HRESET   = 1'b0;
        HBUSREQx = 4'b0010;
        step();
        step();
        lit("split_setup", 4'b0010, 2'd1, 1'b0);
        HRESP    = 2'b11;
        HREADY   = 1'b0;
        HBUSREQx = 4'b1010;
        step();
        lit("split_wait", 4'b0010, 2'd1, 1'b0);
        HREADY = 1'b1;
        step();
        lit("split_p4", 4'b1000, 2'd1, 1'b0);
        HRESP = 2'b00;
        step();
`ifdef AHB_ARB_SPLIT_EN
        lit("split_skip", 4'b1000, 2'd3, 1'b0);
`else
        lit("nosplit_turn", 4'b0010, 2'd3, 1'b0);
`endif
        step();
        HSPLIT = 4'b0010;
        step();
        HSPLIT = 4'b0000;
`ifdef AHB_ARB_SPLIT_EN
        chk("split_still_masked", 32'(HGRANTx), 32'(4'b1000));
`else
        chk("nosplit_p7", 32'(HGRANTx), 32'(4'b0010));
`endif
        step();
`ifdef AHB_ARB_SPLIT_EN
        lit("split_resume", 4'b0010, 2'd3, 1'b0);
`else
        lit("nosplit_p8", 4'b1000, 2'd1, 1'b0);
`endif

        // simultaneous set and clear on the address-phase owner
        HRESP    = 2'b11;
        HREADY   = 1'b0;
        HBUSREQx = 4'b1000;
`ifdef AHB_ARB_SPLIT_EN
        HSPLIT   = 4'b1000;
`else
        HSPLIT   = 4'b0010;
`endif
        step();
        HRESP  = 2'b00;
        HREADY = 1'b1;
        HSPLIT = 4'b0000;
        step();
        chk("collision_grant", 32'(HGRANTx), 32'(4'b1000));
        step();
        chk("collision_keep", 32'(HGRANTx), 32'(4'b1000));

        HBUSREQx = 4'b0000;
        step();
        chk("final_idle", 32'(HGRANTx), 32'(4'b0100));
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter_rr.md
# ahb_arbiter_rr

Parametrised round-robin AHB bus arbiter for up to 16 masters. It supports locked transfers, masks split masters until the slave releases them, and falls back to a default master when the bus is idle. It sits between the master-side HBUSREQx/HLOCKx lines and the address/control multiplexer, which it drives through HMASTER. It replaces the fixed-width, fixed-priority arbiter in the interconnect.

## Interface
- N_MASTERS, 16, number of masters; legal range 2..16
- DEFAULT_MASTER, 0, master granted when there are no eligible requests; must be < N_MASTERS
- MW (localparam), $clog2(N_MASTERS), HMASTER width
- HCLK  in  1  bus clock; all state updates on its rising edge
- HRESET  in  1  synchronous, active-high reset
- HBUSREQx  in  N_MASTERS  per-master bus request
- HLOCKx  in  N_MASTERS  per-master lock request
- HSPLIT  in  N_MASTERS  split-resume pulses from slaves (bit i releases master i)
- HRESP  in  2  current slave response (OKAY=00, ERROR=01, RETRY=10, SPLIT=11)
- HREADY  in  1  transfer-complete / arbitration-enable
- HGRANTx  out  N_MASTERS  one-hot grant
- HMASTER  out  MW  index of the master owning the address phase
- HMASTLOCK  out  1  current address-phase transfer is locked

## Operation
- **Grant invariant:** HGRANTx is always exactly one-hot, never zero and never multiple.
- **Arbitration timing:** evaluated only in cycles with HREADY=1. With HREADY=0 the grant, pointer, HMASTER and HMASTLOCK all hold.
- **Eligibility:** master i is eligible when HBUSREQx[i]=1 and splitmask[i]=0.
- **Lock hold:** if the granted master g has HLOCKx[g]=1 and HBUSREQx[g]=1, the grant stays on g regardless of other requests.
- **Round-robin search:** otherwise, search eligible masters starting at index (last_grant+1) mod N_MASTERS, wrapping around. The first hit wins, and last_grant is set to the winner.
- **Idle fallback:** with no eligible master, grant DEFAULT_MASTER, even if it is masked. last_grant is not updated, so fairness is preserved.
- **HMASTER / HMASTLOCK update:** on an HREADY=1 cycle, HMASTER <= index of the current HGRANTx and HMASTLOCK <= HLOCKx[that index]. This is the address-phase handover.
- **Split set:** a cycle with HRESP=SPLIT and HREADY=0 (first response cycle) sets splitmask[HMASTER].
- **Split clear:** HSPLIT[i]=1 clears splitmask[i].
- **Split set/clear collision:** if a set and a clear hit the same bit in the same cycle, the clear wins.
- **Masked grant release:** a masked master that currently holds the grant loses it at the next arbitration, even if its lock is asserted.

## Timing
- **Reset values:**
  - HGRANTx = 1<<DEFAULT_MASTER
  - HMASTER = DEFAULT_MASTER
  - HMASTLOCK = 0
  - last_grant = DEFAULT_MASTER
  - splitmask = 0
- **Reset mid-transfer:** reset asserted during any cycle forces the reset values on the next edge. No partial state is retained.
- **Grant latency:** request at cycle t with HREADY=1 gives HGRANTx at t+1. HMASTER follows at the first HREADY=1 edge after that, i.e. t+2 with HREADY held high.
- **Grant stability:** a grant never changes on an edge where HREADY=0.
- **Split response:** the split mask takes effect at the arbitration one cycle after the first SPLIT response cycle.
- **HSPLIT latency:** an HSPLIT pulse makes the master eligible at the arbitration in the following cycle.

## Configuration
- Macro: AHB_ARB_SPLIT_EN.
- **Defined:** split masking behaves as described above.
- **Undefined:**
  - no splitmask register is built; eligibility is HBUSREQx only
  - HSPLIT and HRESP are present but ignored
  - split masking never blocks a grant

## Structure
- **Package ahb_arb_pkg:**
  - hresp_t enum (OKAY, ERROR, RETRY, SPLIT)
  - MAX_MASTERS=16
  - function onehot2idx
- **Sub-module rr_pick:** combinational round-robin priority picker (req vector, last index -> one-hot winner plus valid). It is reusable by other arbiters.
- **Top level:** the top holds only the registers plus the lock and split logic.

## Test plan
- Reset with N_MASTERS=4, DEFAULT_MASTER=2 and no requests -> HGRANTx=4'b0100, HMASTER=2, HMASTLOCK=0, held indefinitely.
- HBUSREQx=4'b1111 constant, HREADY=1 -> grants rotate 3,0,1,2,3,... one step per cycle, never two bits set.
- Master 1 requests with HLOCKx[1]=1 while masters 0 and 3 request -> grant stays on 1 until HLOCKx[1] or HBUSREQx[1] drops. During the lock HMASTLOCK=1; the next grant goes to 3.
- HREADY held 0 for 5 cycles while requests change -> HGRANTx, HMASTER and HMASTLOCK unchanged; they update on the first edge after HREADY=1.
- With AHB_ARB_SPLIT_EN defined: HMASTER=1, HRESP=SPLIT with HREADY=0 -> master 1 is skipped despite requesting. HSPLIT[1] pulse -> master 1 is granted within 2 cycles. A simultaneous set and clear leaves the mask clear.
- With AHB_ARB_SPLIT_EN undefined, repeat the previous scenario -> master 1 keeps being granted in its round-robin turn.
